// File: rtl/sram_pkg.sv
// Shared types and default sizes for the external SRAM arbiter.
package sram_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_TURN} sram_state_t;
    typedef enum logic {G_WRITE, G_READ} grant_t;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin owner of the external 16-bit SRAM: serialises recorder writes and
// player reads and sequences the SRAM control pins with fixed access timing.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    sram_state_t       state, state_nxt;
    grant_t            last_grant, grant_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] wdata;
    logic              dq_oe, byte_n;
    logic              ce_n_nxt, oe_n_nxt, we_n_nxt, byte_n_nxt, dq_oe_nxt;
    logic              wr_ack_nxt, rd_ack_nxt;
    logic              take_wr, take_rd, capture;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        grant_nxt  = last_grant;
        ce_n_nxt   = 1'b1;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        byte_n_nxt = 1'b1;
        dq_oe_nxt  = 1'b0;
        wr_ack_nxt = 1'b0;
        rd_ack_nxt = 1'b0;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                // On a tie the port that was not served last wins.
                if (i_wr_req && (!i_rd_req || last_grant == G_READ)) begin
                    take_wr = 1'b1;
                end else if (i_rd_req) begin
                    take_rd = 1'b1;
                end
                if (take_wr) begin
                    state_nxt  = S_WRITE;
                    grant_nxt  = G_WRITE;
                    cnt_nxt    = '0;
                    ce_n_nxt   = 1'b0;
                    byte_n_nxt = 1'b0;
                    we_n_nxt   = 1'b0;
                    dq_oe_nxt  = 1'b1;
                end else if (take_rd) begin
                    state_nxt  = S_READ;
                    grant_nxt  = G_READ;
                    cnt_nxt    = '0;
                    ce_n_nxt   = 1'b0;
                    byte_n_nxt = 1'b0;
                    oe_n_nxt   = 1'b0;
                end
            end
            S_WRITE: begin
                // Data keeps driving through the turnaround cycle for hold time.
                dq_oe_nxt = 1'b1;
                if (cnt == CNT_W'(WR_CYCLES - 1)) begin
                    state_nxt  = S_TURN;
                    wr_ack_nxt = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 1'b1;
                    ce_n_nxt   = 1'b0;
                    byte_n_nxt = 1'b0;
                    we_n_nxt   = 1'b0;
                end
            end
            S_READ: begin
                if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                    state_nxt  = S_TURN;
                    rd_ack_nxt = 1'b1;
                    capture    = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 1'b1;
                    ce_n_nxt   = 1'b0;
                    byte_n_nxt = 1'b0;
                    oe_n_nxt   = 1'b0;
                end
            end
            S_TURN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= G_READ;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            byte_n     <= 1'b1;
            dq_oe      <= 1'b0;
            SRAM_ADDR  <= '0;
            o_wr_ack   <= 1'b0;
            o_rd_ack   <= 1'b0;
            o_rd_data  <= '0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= grant_nxt;
            SRAM_CE_N  <= ce_n_nxt;
            SRAM_OE_N  <= oe_n_nxt;
            SRAM_WE_N  <= we_n_nxt;
            byte_n     <= byte_n_nxt;
            dq_oe      <= dq_oe_nxt;
            o_wr_ack   <= wr_ack_nxt;
            o_rd_ack   <= rd_ack_nxt;
            o_busy     <= (state_nxt != S_IDLE);
            if (take_wr) begin
                SRAM_ADDR <= i_wr_addr;
            end else if (take_rd) begin
                SRAM_ADDR <= i_rd_addr;
            end
            if (capture) begin
                o_rd_data <= SRAM_DQ;
            end
        end
    end

    // Write data is a pure datapath latch; dq_oe gates whether it reaches the pins.
    always_ff @(posedge i_clk) begin
        if (take_wr) begin
            wdata <= i_wr_data;
        end
    end

    assign SRAM_DQ   = dq_oe ? wdata : {DATA_W{1'bz}};
    assign SRAM_UB_N = byte_n;
    assign SRAM_LB_N = byte_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM on the pins.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, rd_ack, busy;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(NC), .RD_CYCLES(NC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
        .o_busy(busy), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
    );

    // Behavioural asynchronous SRAM: stores on clock edges while selected for write.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] sram_rd = '0;
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_rd : {DW{1'bz}};

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && !sram_ub_n && !sram_lb_n) mem[sram_addr] = sram_dq;
    end
    always @(negedge clk) begin
        sram_rd = mem.exists(sram_addr) ? mem[sram_addr] : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One complete access from an idle cycle; returns at the next idle cycle.
    task automatic do_access(input string nm, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] exp);
        bit done = 1'b0;
        if (wr) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
        else begin rd_req = 1'b1; rd_addr = a; end
        for (int k = 1; k <= 20 && !done; k++) begin
            tick();
            if (wr ? wr_ack : rd_ack) begin
                done = 1'b1;
                chk({nm, "_latency"}, k, NC + 1);
                if (!wr) chk({nm, "_rdata"}, rd_data, exp);
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
        end
        if (!done) begin
            chk({nm, "_ack_timeout"}, 0, 1);
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        tick();
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [DW-1:0] ref_mem [logic [AW-1:0]];
        bit            we_seen;
        int            free_c, busy_from, wr_ack_at, rd_ack_at;
        bit            last_w;
        logic [DW-1:0] exp_rd, pend_rd;

        vecs[0] = '{1'b1, 20'h00000, 16'h1111, 16'h0000};
        vecs[1] = '{1'b1, 20'hFFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{1'b0, 20'h00000, 16'h0000, 16'h1111};
        vecs[3] = '{1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{1'b0, 20'h00012, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b1, 20'h00012, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 20'h00012, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 20'h55555, 16'hA5A5, 16'h0000};
        vecs[8] = '{1'b0, 20'h55555, 16'h0000, 16'hA5A5};
        vecs[9] = '{1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF};

        // Reset mid-write, then a tie after reset must go to write.
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        wr_req = 1'b1; wr_addr = 20'h12345; wr_data = 16'hA5A5;
        rd_req = 1'b1; rd_addr = 20'h00777;
        tick();
        chk("tie_first_we_n", sram_we_n, 0);
        chk("tie_first_oe_n", sram_oe_n, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_pins_n", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
        chk("midrst_acks", {wr_ack, rd_ack}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", sram_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("postrst_no_ack", {wr_ack, rd_ack, sram_we_n}, 3'b001);
        tick();
        chk("postrst_tie_we_n", sram_we_n, 0);
        chk("postrst_tie_oe_n", sram_oe_n, 1);
        chk("postrst_tie_addr", sram_addr, 20'h12345);

        // Single write with pin timing.
        do_reset();
        wr_req = 1'b1; wr_addr = 20'h00012; wr_data = 16'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("wr_we_n_c%0d", k), sram_we_n, (k <= 2) ? 0 : 1);
            chk($sformatf("wr_ce_n_c%0d", k), sram_ce_n, (k <= 2) ? 0 : 1);
            chk($sformatf("wr_ack_c%0d", k), wr_ack, (k == 3) ? 1 : 0);
            chk($sformatf("wr_busy_c%0d", k), busy, (k <= 3) ? 1 : 0);
            if (k <= 3) chk($sformatf("wr_dq_c%0d", k), sram_dq, 16'hBEEF);
            if (k == 3) wr_req = 1'b0;
        end
        chk("wr_mem", mem.exists(20'h00012) ? mem[20'h00012] : 16'h0, 16'hBEEF);

        // Single read of the word just written.
        rd_req = 1'b1; rd_addr = 20'h00012;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("rd_oe_n_c%0d", k), sram_oe_n, (k <= 2) ? 0 : 1);
            chk($sformatf("rd_we_n_c%0d", k), sram_we_n, 1);
            chk($sformatf("rd_ack_c%0d", k), rd_ack, (k == 3) ? 1 : 0);
            if (k == 3) begin
                chk("rd_data", rd_data, 16'hBEEF);
                rd_req = 1'b0;
            end
        end
        chk("rd_data_hold", rd_data, 16'hBEEF);

        for (int i = 0; i < 10; i++)
            do_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);

        // Write pulse while a read is busy is lost; a held read is re-served.
        rd_req = 1'b1; rd_addr = 20'hFFFFF;
        we_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (!sram_we_n) we_seen = 1'b1;
            if (k == 1) begin wr_req = 1'b1; wr_addr = 20'h00999; wr_data = 16'h7777; end
            if (k == 2) wr_req = 1'b0;
            if (k == 3) begin chk("hold_rd_ack1", rd_ack, 1); chk("hold_rd_data", rd_data, 16'hFFFF); end
            if (k == 4) chk("hold_idle", {busy, rd_ack, sram_oe_n}, 3'b001);
            if (k == 5) begin chk("hold_second_rd", sram_oe_n, 0); rd_req = 1'b0; end
            if (k == 7) chk("hold_rd_ack2", rd_ack, 1);
        end
        chk("pulse_no_write", we_seen, 0);
        chk("pulse_no_mem", mem.exists(20'h00999), 0);

        // Both requests held from reset: strict alternation starting with write.
        do_reset();
        wr_req = 1'b1; wr_addr = 20'h00100; wr_data = 16'h4242;
        rd_req = 1'b1; rd_addr = 20'h00100;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("rr_we_n_c%0d", k), sram_we_n, (k % 8 == 1 || k % 8 == 2) ? 0 : 1);
            chk($sformatf("rr_oe_n_c%0d", k), sram_oe_n, (k % 8 == 5 || k % 8 == 6) ? 0 : 1);
            chk($sformatf("rr_acks_c%0d", k), {wr_ack, rd_ack},
                (k % 8 == 3) ? 2'b10 : (k % 8 == 7) ? 2'b01 : 2'b00);
            if (k == 7) chk("rr_rd_data", rd_data, 16'h4242);
        end

        // Random requesters against a timeline model of the arbiter.
        do_reset();
        free_c = 0; busy_from = 0; wr_ack_at = -1; rd_ack_at = -1;
        last_w = 1'b0; exp_rd = '0; pend_rd = '0;
        for (int c = 0; c < 1500; c++) begin
            if (c == rd_ack_at) exp_rd = pend_rd;
            chk("rnd_wr_ack", wr_ack, (c == wr_ack_at) ? 1 : 0);
            chk("rnd_rd_ack", rd_ack, (c == rd_ack_at) ? 1 : 0);
            chk("rnd_busy", busy, (c >= busy_from && c < free_c) ? 1 : 0);
            chk("rnd_rd_data", rd_data, exp_rd);
            chk("rnd_no_overlap", !sram_we_n && !sram_oe_n, 0);
            if (wr_ack) wr_req = 1'b0;
            if (rd_ack) rd_req = 1'b0;
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1'b1;
                wr_addr = 20'h80000 + 20'($urandom_range(0, 15));
                wr_data = 16'($urandom);
            end else if (wr_req && $urandom_range(0, 31) == 0) begin
                wr_req = 1'b0;
            end
            if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1;
                rd_addr = 20'h80000 + 20'($urandom_range(0, 15));
            end else if (rd_req && $urandom_range(0, 31) == 0) begin
                rd_req = 1'b0;
            end
            if (c >= free_c && (wr_req || rd_req)) begin
                if (wr_req && (!rd_req || !last_w)) begin
                    ref_mem[wr_addr] = wr_data;
                    last_w = 1'b1;
                    wr_ack_at = c + NC + 1;
                end else begin
                    pend_rd = ref_mem.exists(rd_addr) ? ref_mem[rd_addr] : '0;
                    last_w = 1'b0;
                    rd_ack_at = c + NC + 1;
                end
                busy_from = c + 1;
                free_c = c + NC + 2;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
